// File: rtl/mips8_mc_controller_if.sv
// Control bundle between the multicycle controller and the datav datapath / memory.
// The master modport is the controller side; the slave modport is the datapath side.
interface mips8_mc_controller_if;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic       memtoreg;
    logic       regdst;
    logic       iord;
    logic       pcen;
    logic [1:0] pcsrc;
    logic       regwrite;
    logic [3:0] irwrite;
    logic [2:0] alucontrol;
    logic       memread;
    logic       memwrite;
    logic [3:0] state;
    logic       instr_done;
    logic       illegal;

    modport master (
        input  op, funct, zero,
        output alusrca, alusrcb, memtoreg, regdst, iord, pcen, pcsrc, regwrite,
               irwrite, alucontrol, memread, memwrite, state, instr_done, illegal
    );

    modport slave (
        output op, funct, zero,
        input  alusrca, alusrcb, memtoreg, regdst, iord, pcen, pcsrc, regwrite,
               irwrite, alucontrol, memread, memwrite, state, instr_done, illegal
    );
endinterface

// File: rtl/mips8_mc_controller.sv
// Multicycle control FSM for the 8-bit MIPS-subset datapath: byte-beat fetch, then
// per-opcode sequencing. Optional addi support is enabled by defining CTRL_ADDI_EN.
//
// state    | code | meaning
// FETCHk   | 0..3 | fetch instruction byte k, PC += 1
// DECODE   | 4    | branch target into ALUOut, dispatch on op
// MEMADR   | 5    | A + imm for lb/sb
// LBRD     | 6    | read memory at ALUOut
// LBWR     | 7    | MDR -> rt
// SBWR     | 8    | write memory at ALUOut
// RTYPEEX  | 9    | A op B
// RTYPEWR  | 10   | ALUOut -> rd
// BEQEX    | 11   | A - B, branch on zero
// JEX      | 12   | PC <- jump target
// ADDIEX   | 13   | A + imm (CTRL_ADDI_EN only)
// ADDIWR   | 14   | ALUOut -> rt (CTRL_ADDI_EN only)
module mips8_mc_controller #(
    parameter int FETCH_BEATS = 4
) (
    input  logic clk,
    input  logic reset,
    mips8_mc_controller_if.master bus
);

    typedef enum logic [3:0] {
        S_FETCH1  = 4'd0,
        S_FETCH2  = 4'd1,
        S_FETCH3  = 4'd2,
        S_FETCH4  = 4'd3,
        S_DECODE  = 4'd4,
        S_MEMADR  = 4'd5,
        S_LBRD    = 4'd6,
        S_LBWR    = 4'd7,
        S_SBWR    = 4'd8,
        S_RTYPEEX = 4'd9,
        S_RTYPEWR = 4'd10,
        S_BEQEX   = 4'd11,
        S_JEX     = 4'd12,
        S_ADDIEX  = 4'd13,
        S_ADDIWR  = 4'd14,
        S_UNUSED  = 4'd15
    } state_t;

    typedef struct packed {
        logic       alusrca;
        logic [1:0] alusrcb;
        logic       memtoreg;
        logic       regdst;
        logic       iord;
        logic       pcwrite;
        logic       branch;
        logic [1:0] pcsrc;
        logic       regwrite;
        logic [3:0] irwrite;
        logic [2:0] alucontrol;
        logic       memread;
        logic       memwrite;
        logic       instr_done;
    } ctrl_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_SB    = 6'b101000;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    function automatic logic op_legal(input logic [5:0] op);
        logic ok;
        case (op)
            OP_LB, OP_SB, OP_RTYPE, OP_BEQ, OP_J: ok = 1'b1;
`ifdef CTRL_ADDI_EN
            OP_ADDI: ok = 1'b1;
`endif
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [2:0] funct_alu(input logic [5:0] funct);
        logic [2:0] a;
        case (funct)
            6'b100010: a = ALU_SUB;
            6'b100100: a = ALU_AND;
            6'b100101: a = ALU_OR;
            6'b101010: a = ALU_SLT;
            default:   a = ALU_ADD;
        endcase
        return a;
    endfunction

    function automatic state_t next_state(input state_t s, input logic [5:0] op);
        state_t n;
        n = S_FETCH1;
        if (s < 4'(FETCH_BEATS)) begin
            n = (s == 4'(FETCH_BEATS - 1)) ? S_DECODE : state_t'(s + 4'd1);
        end else begin
            case (s)
                S_DECODE: begin
                    case (op)
                        OP_LB, OP_SB: n = S_MEMADR;
                        OP_RTYPE:     n = S_RTYPEEX;
                        OP_BEQ:       n = S_BEQEX;
                        OP_J:         n = S_JEX;
`ifdef CTRL_ADDI_EN
                        OP_ADDI:      n = S_ADDIEX;
`endif
                        default:      n = S_FETCH1;
                    endcase
                end
                S_MEMADR:  n = (op == OP_LB) ? S_LBRD : S_SBWR;
                S_LBRD:    n = S_LBWR;
                S_RTYPEEX: n = S_RTYPEWR;
`ifdef CTRL_ADDI_EN
                S_ADDIEX:  n = S_ADDIWR;
`endif
                default:   n = S_FETCH1;
            endcase
        end
        return n;
    endfunction

    function automatic ctrl_t ctrl_for(input state_t s);
        ctrl_t c;
        c = '0;
        c.alucontrol = ALU_ADD;
        if (s < 4'(FETCH_BEATS)) begin
            c.memread = 1'b1;
            c.alusrcb = 2'b01;
            c.pcwrite = 1'b1;
            c.irwrite = 4'b0001 << s;
        end else begin
            case (s)
                S_DECODE:  c.alusrcb = 2'b11;
                S_MEMADR: begin
                    c.alusrca = 1'b1;
                    c.alusrcb = 2'b10;
                end
                S_LBRD: begin
                    c.iord    = 1'b1;
                    c.memread = 1'b1;
                end
                S_LBWR: begin
                    c.regwrite   = 1'b1;
                    c.memtoreg   = 1'b1;
                    c.instr_done = 1'b1;
                end
                S_SBWR: begin
                    c.iord       = 1'b1;
                    c.memwrite   = 1'b1;
                    c.instr_done = 1'b1;
                end
                S_RTYPEEX: c.alusrca = 1'b1;
                S_RTYPEWR: begin
                    c.regwrite   = 1'b1;
                    c.regdst     = 1'b1;
                    c.instr_done = 1'b1;
                end
                S_BEQEX: begin
                    c.alusrca    = 1'b1;
                    c.alucontrol = ALU_SUB;
                    c.branch     = 1'b1;
                    c.pcsrc      = 2'b01;
                    c.instr_done = 1'b1;
                end
                S_JEX: begin
                    c.pcwrite    = 1'b1;
                    c.pcsrc      = 2'b10;
                    c.instr_done = 1'b1;
                end
`ifdef CTRL_ADDI_EN
                S_ADDIEX: begin
                    c.alusrca = 1'b1;
                    c.alusrcb = 2'b10;
                end
                S_ADDIWR: begin
                    c.regwrite   = 1'b1;
                    c.instr_done = 1'b1;
                end
`endif
                default: c = '0;
            endcase
        end
        return c;
    endfunction

    state_t state_q, state_d;
    ctrl_t  ctrl_q, ctrl_o;

    always_comb state_d = next_state(state_q, bus.op);

    // Control word is registered alongside the state so it always matches state_q.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH1;
            ctrl_q  <= ctrl_for(S_FETCH1);
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_for(state_d);
        end
    end

    // Reset shows FETCH1 steering with every strobe held off, even mid-instruction.
    always_comb begin
        ctrl_o = ctrl_q;
        if (state_q == S_RTYPEEX) ctrl_o.alucontrol = funct_alu(bus.funct);
        if (reset) begin
            ctrl_o         = ctrl_for(S_FETCH1);
            ctrl_o.memread = 1'b0;
            ctrl_o.irwrite = 4'b0000;
            ctrl_o.pcwrite = 1'b0;
        end
    end

    assign bus.alusrca    = ctrl_o.alusrca;
    assign bus.alusrcb    = ctrl_o.alusrcb;
    assign bus.memtoreg   = ctrl_o.memtoreg;
    assign bus.regdst     = ctrl_o.regdst;
    assign bus.iord       = ctrl_o.iord;
    assign bus.pcen       = ctrl_o.pcwrite | (ctrl_o.branch & bus.zero);
    assign bus.pcsrc      = ctrl_o.pcsrc;
    assign bus.regwrite   = ctrl_o.regwrite;
    assign bus.irwrite    = ctrl_o.irwrite;
    assign bus.alucontrol = ctrl_o.alucontrol;
    assign bus.memread    = ctrl_o.memread;
    assign bus.memwrite   = ctrl_o.memwrite;
    assign bus.instr_done = ctrl_o.instr_done;
    assign bus.state      = state_q;
    assign bus.illegal    = ~reset & (state_q == S_DECODE) & ~op_legal(bus.op);

endmodule

// File: tb/tb_mips8_mc_controller.sv
// Self-checking bench for mips8_mc_controller: reset and mid-op reset sequences, a
// vector table of opcodes, and random instruction streams against a sequence model.
module tb_mips8_mc_controller;

    localparam int FB = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mips8_mc_controller_if bus();

    mips8_mc_controller #(.FETCH_BEATS(FB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;
    int seq[$];

    typedef struct {
        logic [5:0] op;
        logic [5:0] funct;
        int         zmode;
        int         len;
        string      name;
    } vec_t;

    vec_t vecs[13];

    function automatic logic legal(input logic [5:0] o);
        logic ok;
        ok = (o == 6'b100000) || (o == 6'b101000) || (o == 6'b000000) ||
             (o == 6'b000100) || (o == 6'b000010);
`ifdef CTRL_ADDI_EN
        ok = ok || (o == 6'b001000);
`endif
        return ok;
    endfunction

    // State codes an instruction visits, from opcode alone.
    function automatic void build_seq(input logic [5:0] o);
        seq.delete();
        for (int k = 0; k < FB; k++) seq.push_back(k);
        seq.push_back(4);
        if (o == 6'b100000) begin seq.push_back(5); seq.push_back(6); seq.push_back(7); end
        else if (o == 6'b101000) begin seq.push_back(5); seq.push_back(8); end
        else if (o == 6'b000000) begin seq.push_back(9); seq.push_back(10); end
        else if (o == 6'b000100) seq.push_back(11);
        else if (o == 6'b000010) seq.push_back(12);
`ifdef CTRL_ADDI_EN
        else if (o == 6'b001000) begin seq.push_back(13); seq.push_back(14); end
`endif
    endfunction

    function automatic logic [2:0] alu_of(input logic [5:0] f);
        case (f)
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    // Expected output word for a state code: {state, alusrca, alusrcb, memtoreg, regdst,
    // iord, pcen, pcsrc, regwrite, irwrite, alucontrol, memread, memwrite, done, illegal}.
    function automatic logic [24:0] exp_sig(input int code, input logic [5:0] o, f,
                                            input logic z, input logic rst);
        logic       a = 0, mtr = 0, rd = 0, io = 0, pe = 0, rw = 0, mr = 0, mw = 0, dn = 0, il = 0;
        logic [1:0] b = 0, ps = 0;
        logic [3:0] ir = 0;
        logic [2:0] alu = 3'b010;
        if (rst) begin
            b = 2'b01;
        end else if (code < FB) begin
            mr = 1; b = 2'b01; pe = 1; ir = 4'(1 << code);
        end else begin
            case (code)
                4:  begin b = 2'b11; il = !legal(o); end
                5:  begin a = 1; b = 2'b10; end
                6:  begin io = 1; mr = 1; end
                7:  begin rw = 1; mtr = 1; dn = 1; end
                8:  begin io = 1; mw = 1; dn = 1; end
                9:  begin a = 1; alu = alu_of(f); end
                10: begin rw = 1; rd = 1; dn = 1; end
                11: begin a = 1; alu = 3'b110; pe = z; ps = 2'b01; dn = 1; end
                12: begin pe = 1; ps = 2'b10; dn = 1; end
`ifdef CTRL_ADDI_EN
                13: begin a = 1; b = 2'b10; end
                14: begin rw = 1; dn = 1; end
`endif
                default: alu = 3'b000;
            endcase
        end
        return {4'(code), a, b, mtr, rd, io, pe, ps, rw, ir, alu, mr, mw, dn, il};
    endfunction

    function automatic logic [24:0] got_sig();
        return {bus.state, bus.alusrca, bus.alusrcb, bus.memtoreg, bus.regdst, bus.iord,
                bus.pcen, bus.pcsrc, bus.regwrite, bus.irwrite, bus.alucontrol,
                bus.memread, bus.memwrite, bus.instr_done, bus.illegal};
    endfunction

    task automatic cyc(input int code, input logic [5:0] o, f, input logic z,
                       input logic rst, input string name);
        logic [24:0] g, e;
        @(negedge clk);
        reset = rst; bus.op = o; bus.funct = f; bus.zero = z;
        #1;
        g = got_sig();
        e = exp_sig(code, o, f, z, rst);
        total++;
        if (g !== e) begin
            bad++;
            $display("FAIL %s code=%0d got=%07h expected=%07h", name, code, g, e);
        end
    endtask

    task automatic run_instr(input logic [5:0] o, f, input int zmode, input int len,
                             input string name);
        int  n = 0;
        bit  fin = 0;
        logic z;
        build_seq(o);
        while (!fin && n < 20) begin
            z = (zmode == 2) ? 1'($urandom_range(0, 1)) : 1'(zmode);
            cyc((n < seq.size()) ? seq[n] : 15, o, f, z, 1'b0, name);
            n++;
            if (bus.instr_done || bus.illegal) fin = 1;
        end
        total++;
        if (n != len) begin
            bad++;
            $display("FAIL %s latency got=%0d expected=%0d", name, n, len);
        end
    endtask

    initial begin
        logic [5:0] o, f;
        logic [5:0] fset[6];
        bus.op = 6'd0; bus.funct = 6'd0; bus.zero = 1'b0;

        // Reset: strobes forced low even before the first edge.
        #1;
        total++;
        if (bus.pcen !== 1'b0) begin bad++; $display("FAIL reset_pcen got=%b expected=0", bus.pcen); end
        total++;
        if (bus.irwrite !== 4'b0) begin bad++; $display("FAIL reset_irwrite got=%b expected=0000", bus.irwrite); end
        cyc(0, 6'd0, 6'b100000, 1'b0, 1'b1, "reset_hold1");
        cyc(0, 6'd0, 6'b100000, 1'b0, 1'b1, "reset_hold2");
        for (int k = 0; k < FB; k++) cyc(k, 6'd0, 6'b100000, 1'b0, 1'b0, "post_reset_fetch");
        cyc(4, 6'd0, 6'b100000, 1'b0, 1'b0, "post_reset_decode");
        cyc(9, 6'd0, 6'b100000, 1'b0, 1'b0, "post_reset_rex");
        cyc(10, 6'd0, 6'b100000, 1'b0, 1'b0, "post_reset_rwr");

        vecs[0]  = '{6'b000000, 6'b100000, 0, 7, "rtype_add"};
        vecs[1]  = '{6'b000000, 6'b101010, 0, 7, "rtype_slt"};
        vecs[2]  = '{6'b000000, 6'b100010, 1, 7, "rtype_sub"};
        vecs[3]  = '{6'b000000, 6'b100100, 0, 7, "rtype_and"};
        vecs[4]  = '{6'b000000, 6'b100101, 0, 7, "rtype_or"};
        vecs[5]  = '{6'b000000, 6'b000111, 0, 7, "rtype_unknown_funct"};
        vecs[6]  = '{6'b000100, 6'b000000, 1, 6, "beq_taken"};
        vecs[7]  = '{6'b000100, 6'b000000, 0, 6, "beq_not_taken"};
        vecs[8]  = '{6'b100000, 6'b000000, 0, 8, "lb"};
        vecs[9]  = '{6'b101000, 6'b000000, 0, 7, "sb"};
        vecs[10] = '{6'b000010, 6'b000000, 0, 6, "j"};
        vecs[11] = '{6'b111111, 6'b000000, 0, 5, "illegal_op"};
`ifdef CTRL_ADDI_EN
        vecs[12] = '{6'b001000, 6'b000000, 0, 7, "addi"};
`else
        vecs[12] = '{6'b001000, 6'b000000, 0, 5, "addi_illegal"};
`endif
        foreach (vecs[i]) run_instr(vecs[i].op, vecs[i].funct, vecs[i].zmode, vecs[i].len, vecs[i].name);

        fset = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b110011};
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 6))
                0: o = 6'b100000;
                1: o = 6'b101000;
                2: o = 6'b000000;
                3: o = 6'b000100;
                4: o = 6'b000010;
                5: o = 6'b001000;
                default: begin
                    o = 6'($urandom_range(0, 63));
                    while (legal(o) || o == 6'b001000) o = 6'($urandom_range(0, 63));
                end
            endcase
            f = fset[$urandom_range(0, 5)];
            build_seq(o);
            run_instr(o, f, 2, seq.size(), "random");
        end

        // Reset in LBRD abandons the load; then a jump runs cleanly.
        for (int k = 0; k < FB; k++) cyc(k, 6'b100000, 6'd0, 1'b0, 1'b0, "midrst_fetch");
        cyc(4, 6'b100000, 6'd0, 1'b0, 1'b0, "midrst_decode");
        cyc(5, 6'b100000, 6'd0, 1'b0, 1'b0, "midrst_memadr");
        cyc(6, 6'b100000, 6'd0, 1'b0, 1'b1, "midrst_lbrd_reset");
        cyc(0, 6'b000010, 6'd0, 1'b0, 1'b0, "midrst_back_fetch1");
        for (int k = 1; k < FB; k++) cyc(k, 6'b000010, 6'd0, 1'b0, 1'b0, "midrst_refetch");
        cyc(4, 6'b000010, 6'd0, 1'b0, 1'b0, "midrst_j_decode");
        cyc(12, 6'b000010, 6'd0, 1'b0, 1'b0, "midrst_jex");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
